// File: rtl/mc_maindec.sv
// Multicycle MIPS-style main decoder: a Moore control FSM that sequences
// fetch / decode / execute / memory / writeback. It also keeps a count of
// retired instructions. Control outputs depend on the current state only;
// the memory-handshake strobes also follow mem_ready.
module mc_maindec #(
   parameter int OPW  = 6,
   parameter int RETW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  op,
   input  logic            mem_ready,
   output logic            memwrite,
   output logic            iord,
   output logic            irwrite,
   output logic            regdst,
   output logic            memtoreg,
   output logic            regwrite,
   output logic            alusrca,
   output logic [1:0]      alusrcb,
   output logic [1:0]      pcsrc,
   output logic [1:0]      aluop,
   output logic            branch,
   output logic            branchne,
   output logic            pcwrite,
   output logic            illegal,
   output logic [RETW-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_BNE     = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12,
      S_ILLEGAL = 4'd13
   } state_t;

   localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
   localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
   localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

   state_t          state_r;
   state_t          next_s;
   logic            retire_s;
   logic [RETW-1:0] retired_r;

   // State register; reset wins over any transition in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; unused encodings fall back to FETCH.
   always_comb begin
      next_s = S_FETCH;
      case (state_r)
         S_FETCH:   next_s = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((op == OP_LW) || (op == OP_SW)) begin
               next_s = S_MEMADR;
            end else if (op == OP_RTYP) begin
               next_s = S_EXECUTE;
            end else if (op == OP_BEQ) begin
               next_s = S_BEQ;
            end else if (op == OP_BNE) begin
               next_s = S_BNE;
            end else if (op == OP_ADDI) begin
               next_s = S_ADDIEX;
            end else if (op == OP_J) begin
               next_s = S_JUMP;
            end else begin
               next_s = S_ILLEGAL;
            end
         end
         S_MEMADR:  next_s = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   next_s = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   next_s = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: next_s = S_ALUWB;
         S_ADDIEX:  next_s = S_ADDIWB;
         default:   next_s = S_FETCH;
      endcase
   end

   // Moore control outputs; everything not listed for a state stays 0.
   always_comb begin
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      branch   = 1'b0;
      branchne = 1'b0;
      pcwrite  = 1'b0;
      illegal  = 1'b0;
      case (state_r)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = mem_ready;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQ: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_BNE: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            branchne = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB:  regwrite = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_ILLEGAL: illegal = 1'b1;
         default:   illegal = 1'b0;
      endcase
   end

   // An instruction retires on the cycle it leaves its final state.
   always_comb begin
      retire_s = 1'b0;
      case (state_r)
         S_MEMWB, S_ALUWB, S_ADDIWB,
         S_BEQ, S_BNE, S_JUMP: retire_s = 1'b1;
         S_MEMWR:              retire_s = mem_ready;
         default:              retire_s = 1'b0;
      endcase
   end

   // Retired-instruction counter, wrapping naturally at 2^RETW.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_r <= {RETW{1'b0}};
      end else if (retire_s) begin
         retired_r <= retired_r + {{(RETW-1){1'b0}}, 1'b1};
      end else begin
         retired_r <= retired_r;
      end
   end

   assign retired = retired_r;

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter OPW, default 6: opcode field width.
REQ-002 Parameter RETW, default 32: retired-instruction counter width.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port op  input  OPW: opcode of the instruction in the instruction register; sampled in DECODE only.
REQ-006 Port mem_ready  input  1: memory handshake; high means the current memory access completes this cycle.
REQ-007 Ports memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca  output  1 each: datapath strobes and selects.
REQ-008 Ports alusrcb, pcsrc, aluop  output  2 each: ALU B select, PC source select, ALU op class.
REQ-009 Ports branch, branchne, pcwrite  output  1 each: branch-if-zero, branch-if-not-zero, unconditional PC write.
REQ-010 Port illegal  output  1: one-cycle pulse on an unsupported opcode.
REQ-011 Port retired  output  RETW: count of completed instructions.

Function
REQ-012 The block SHALL be a Moore FSM; every control output SHALL be a function of the current state (and mem_ready where stated) only, and SHALL be 0 in every state that does not list it.
REQ-013 States and outputs: FETCH iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready; DECODE alusrcb=11; MEMADR alusrca=1, alusrcb=10; MEMRD iord=1; MEMWB memtoreg=1, regwrite=1; MEMWR iord=1, memwrite=mem_ready; EXECUTE alusrca=1, aluop=10; ALUWB regdst=1, regwrite=1; BEQ alusrca=1, aluop=01, pcsrc=01, branch=1; BNE as BEQ but branchne=1, branch=0; ADDIEX alusrca=1, alusrcb=10; ADDIWB regwrite=1; JUMP pcsrc=10, pcwrite=1; ILLEGAL illegal=1.
REQ-014 FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0; when mem_ready=1, FETCH->DECODE, MEMRD->MEMWB, MEMWR->FETCH.
REQ-015 DECODE SHALL branch on op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BEQ; 000101 -> BNE; 001000 -> ADDIEX; 000010 -> JUMP; any other value -> ILLEGAL.
REQ-016 MEMADR SHALL go to MEMRD if op=100011, else to MEMWR; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-017 MEMWB, ALUWB, ADDIWB, BEQ, BNE, JUMP and ILLEGAL SHALL each go to FETCH after one cycle.
REQ-018 retired SHALL increment by 1 on the cycle leaving MEMWB, ALUWB, ADDIWB, BEQ, BNE or JUMP, and on MEMWR with mem_ready=1; ILLEGAL SHALL NOT increment.
REQ-019 retired SHALL wrap modulo 2^RETW without flag or saturation.
REQ-020 Latencies with mem_ready held high: R-type 4, LW 5, SW 4, BEQ/BNE 3, ADDI 4, J 3 cycles, counted from FETCH entry to FETCH re-entry.
REQ-021 Unused state encodings SHALL transition to FETCH on the next clock with all outputs 0.

Reset
REQ-022 With reset=1 at a clock edge, state SHALL become FETCH and retired SHALL become 0, overriding any transition or increment in that cycle.
REQ-023 Reset asserted mid-instruction (including during a memory wait) SHALL abandon it without counting it; after reset outputs SHALL equal FETCH outputs.
REQ-024 No output SHALL be X after the first reset edge.

Verification
REQ-025 Reset, mem_ready=1, op=000000 -> states FETCH, DECODE, EXECUTE, ALUWB, FETCH; regwrite=1 and regdst=1 only in ALUWB; retired=1.
REQ-026 op=100011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=1 throughout; then MEMWB with memtoreg=1; retired increments once.
REQ-027 op=000101 -> BNE cycle with branchne=1, branch=0, pcsrc=01, aluop=01; op=000100 -> branch=1, branchne=0.
REQ-028 op=111111 -> illegal=1 for exactly one cycle, then FETCH; retired unchanged.
REQ-029 RETW=4, run 17 ADDI instructions -> retired wraps 15->0, reads 1 at end.
REQ-030 Reset asserted in MEMWR with mem_ready=1 -> next state FETCH, retired=0, memwrite low after the edge.
